// File: rtl/wb_openram_pkg.sv
// Shared definitions for the Wishbone-to-OpenRAM round-robin arbiter:
// FSM state encoding, latency counter width and the address window match.
package wb_openram_pkg;

    // Access sequencer states; the encoding is visible on dbg_state.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } state_t;

    // Wide enough to count READ_LATENCY up to 4.
    localparam int LAT_CNT_W = 3;

    // True when adr falls in the window of base: every bit above the
    // RAM word address and byte offset must match.
    function automatic logic window_hit(
        input logic [31:0] adr,
        input logic [31:0] base,
        input int unsigned addr_width
    );
        logic [31:0] mask;
        mask = 32'hFFFF_FFFF << (addr_width + 2);
        return ((adr ^ base) & mask) == 32'h0;
    endfunction

endpackage

// File: rtl/wb_rr_arbiter.sv
// Combinational round-robin arbiter. The search starts at last_grant+1 and
// wraps around, so the port granted most recently has the lowest priority.
module wb_rr_arbiter #(
    parameter int NUM_PORTS = 2,
    parameter int IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_W-1:0]     last_grant,
    output logic [NUM_PORTS-1:0] grant,
    output logic [IDX_W-1:0]     grant_idx,
    output logic                 grant_valid
);

    // First pass covers ports above last_grant, second pass wraps to 0..last_grant.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!grant_valid && req[i] && (i > int'(last_grant))) begin
                grant_valid = 1'b1;
                grant[i]    = 1'b1;
                grant_idx   = IDX_W'(i);
            end
        end
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!grant_valid && req[i] && (i <= int'(last_grant))) begin
                grant_valid = 1'b1;
                grant[i]    = 1'b1;
                grant_idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/wb_openram_arbiter.sv
// NUM_PORTS Wishbone slave ports sharing one OpenRAM read/write port.
// Optional feature macro: WB_OPENRAM_ERR_EN adds wbs_err_o, a one-cycle
// error strobe for requests that miss the port's address window.
//
// Handshake: a port requests with cyc&stb held high and must hold its
// address/data/sel/we until it sees ack (or err) high, dropping stb at
// that clock edge. The block answers each accepted request with exactly
// one ack cycle; a request whose cyc falls before ack is completed on the
// RAM side but never acked.
module wb_openram_arbiter
    import wb_openram_pkg::*;
#(
    parameter int                      NUM_PORTS    = 2,
    parameter int                      ADDR_WIDTH   = 8,
    parameter logic [NUM_PORTS*32-1:0] BASE_ADDRS   = {NUM_PORTS{32'h3000_0000}},
    parameter int                      READ_LATENCY = 1
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,
    input  logic [NUM_PORTS-1:0]      wbs_stb_i,
    input  logic [NUM_PORTS-1:0]      wbs_cyc_i,
    input  logic [NUM_PORTS-1:0]      wbs_we_i,
    input  logic [4*NUM_PORTS-1:0]    wbs_sel_i,
    input  logic [32*NUM_PORTS-1:0]   wbs_dat_i,
    input  logic [32*NUM_PORTS-1:0]   wbs_adr_i,
    output logic [NUM_PORTS-1:0]      wbs_ack_o,
    output logic [32*NUM_PORTS-1:0]   wbs_dat_o,
`ifdef WB_OPENRAM_ERR_EN
    output logic [NUM_PORTS-1:0]      wbs_err_o,
`endif
    output logic                      ram_clk0,
    output logic                      ram_csb0,
    output logic                      ram_web0,
    output logic [3:0]                ram_wmask0,
    output logic [ADDR_WIDTH-1:0]     ram_addr0,
    output logic [31:0]               ram_din0,
    input  logic [31:0]               ram_dout0,
    output logic [1:0]                dbg_state
);

    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    state_t                 state_q;
    state_t                 state_d;

    logic [NUM_PORTS-1:0]   win;
    logic [NUM_PORTS-1:0]   hit;
    logic [NUM_PORTS-1:0]   arb_onehot;
    logic [IDX_W-1:0]       arb_idx;
    logic                   arb_valid;

    logic                   req_we;
    logic [3:0]             req_sel;
    logic [ADDR_WIDTH-1:0]  req_addr;
    logic [31:0]            req_dat;
    logic                   gnt_cyc;

    logic [IDX_W-1:0]       grant_q;
    logic [IDX_W-1:0]       last_grant_q;
    logic                   we_q;
    logic [3:0]             sel_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [31:0]            din_q;
    logic [LAT_CNT_W-1:0]   lat_cnt_q;
    logic                   lat_done;
    logic                   abandon_q;
    logic [31:0]            dat_q [NUM_PORTS];

    assign ram_clk0  = wb_clk_i;
    assign dbg_state = state_q;
    assign lat_done  = (lat_cnt_q == LAT_CNT_W'(READ_LATENCY - 1));

    // Per-port window decode and in-window request vector.
    always_comb begin
        win = '0;
        hit = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            win[i] = window_hit(wbs_adr_i[32*i +: 32], BASE_ADDRS[32*i +: 32], ADDR_WIDTH);
            hit[i] = wbs_cyc_i[i] & wbs_stb_i[i] & win[i];
        end
    end

    wb_rr_arbiter #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_arb (
        .req         (hit),
        .last_grant  (last_grant_q),
        .grant       (arb_onehot),
        .grant_idx   (arb_idx),
        .grant_valid (arb_valid)
    );

    // Select the bus fields of the port being granted, and cyc of the port holding the grant.
    always_comb begin
        req_we   = 1'b0;
        req_sel  = '0;
        req_addr = '0;
        req_dat  = '0;
        gnt_cyc  = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (arb_idx == IDX_W'(i)) begin
                req_we   = wbs_we_i[i];
                req_sel  = wbs_sel_i[4*i +: 4];
                req_addr = wbs_adr_i[32*i+2 +: ADDR_WIDTH];
                req_dat  = wbs_dat_i[32*i +: 32];
            end
            if (grant_q == IDX_W'(i)) begin
                gnt_cyc = wbs_cyc_i[i];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: one RAM access per grant, reads wait out the RAM latency.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (arb_valid) state_d = ISSUE;
            ISSUE:   state_d = we_q ? ACK : WAIT;
            WAIT:    if (lat_done) state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Capture the granted request, track abandonment, count read latency, rotate priority.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            grant_q      <= '0;
            last_grant_q <= IDX_W'(NUM_PORTS - 1);
            we_q         <= 1'b0;
            sel_q        <= '0;
            addr_q       <= '0;
            din_q        <= '0;
            lat_cnt_q    <= '0;
            abandon_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (arb_valid) begin
                        grant_q   <= arb_idx;
                        we_q      <= req_we;
                        sel_q     <= req_sel;
                        addr_q    <= req_addr;
                        din_q     <= req_dat;
                        lat_cnt_q <= '0;
                        abandon_q <= 1'b0;
                    end
                end
                ISSUE: begin
                    if (!gnt_cyc) abandon_q <= 1'b1;
                end
                WAIT: begin
                    if (!gnt_cyc) abandon_q <= 1'b1;
                    lat_cnt_q <= lat_cnt_q + LAT_CNT_W'(1);
                end
                ACK: begin
                    last_grant_q <= grant_q;
                end
                default: ;
            endcase
        end
    end

    // Read data lands in the granted port's register even if the request was abandoned.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            for (int i = 0; i < NUM_PORTS; i++) dat_q[i] <= '0;
        end else if (state_q == WAIT && lat_done) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (grant_q == IDX_W'(i)) dat_q[i] <= ram_dout0;
            end
        end
    end

    // Flatten the per-port read data registers onto the output bus.
    always_comb begin
        wbs_dat_o = '0;
        for (int i = 0; i < NUM_PORTS; i++) wbs_dat_o[32*i +: 32] = dat_q[i];
    end

    // Ack the granted port for the single ACK cycle unless its cyc dropped.
    always_comb begin
        wbs_ack_o = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (state_q == ACK && !abandon_q && grant_q == IDX_W'(i)) wbs_ack_o[i] = 1'b1;
        end
    end

    // RAM strobes are active only in ISSUE; address and data hold their last captured value.
    always_comb begin
        ram_csb0   = 1'b1;
        ram_web0   = 1'b1;
        ram_wmask0 = 4'h0;
        if (state_q == ISSUE) begin
            ram_csb0   = 1'b0;
            ram_web0   = !we_q;
            ram_wmask0 = we_q ? sel_q : 4'hF;
        end
    end

    assign ram_addr0 = addr_q;
    assign ram_din0  = din_q;

`ifdef WB_OPENRAM_ERR_EN
    logic [NUM_PORTS-1:0] miss;
    logic [NUM_PORTS-1:0] err_q;

    // Out-of-window requests: no RAM access and no arbitration slot.
    always_comb begin
        miss = wbs_cyc_i & wbs_stb_i & ~win;
    end

    // One-cycle error pulse; the ~err_q term keeps it single while stb is still high at the err edge.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            err_q <= '0;
        end else begin
            err_q <= miss & ~err_q;
        end
    end

    assign wbs_err_o = err_q;
`else
    // Out-of-window requests are left unanswered so another slave can claim them.
`endif

endmodule

// File: doc/wb_openram_arbiter.md
# wb_openram_arbiter

Parametrised successor to the two-port Wishbone/OpenRAM wrapper: connects NUM_PORTS Wishbone slave ports, all on a single clock, to one OpenRAM read/write port through a round-robin arbiter. Each port has its own base-address window. Accesses are serialised, with byte-masked writes and a configurable RAM read latency. The block sits between the user-area Wishbone buses and one sky130 OpenRAM macro instance.

## Interface
Parameters:
- NUM_PORTS, 2, number of Wishbone slave ports (1..8).
- ADDR_WIDTH, 8, RAM word-address width.
- BASE_ADDRS, {NUM_PORTS{32'h3000_0000}}, packed NUM_PORTS*32 base addresses; port i uses bits [32*i+31:32*i].
- READ_LATENCY, 1, cycles from RAM sampling edge to ram_dout0 valid (1..4).

Ports (per-port buses flattened, port i at slice i):
- wb_clk_i  in  1  single clock for all ports and the RAM.
- wb_rst_i  in  1  asynchronous, active-high reset.
- wbs_stb_i / wbs_cyc_i / wbs_we_i  in  NUM_PORTS each  Wishbone strobe / cycle / write enable.
- wbs_sel_i  in  4*NUM_PORTS  byte selects.
- wbs_dat_i  in  32*NUM_PORTS  write data.
- wbs_adr_i  in  32*NUM_PORTS  byte addresses.
- wbs_ack_o  out  NUM_PORTS  acknowledge.
- wbs_dat_o  out  32*NUM_PORTS  read data, registered per port.
- wbs_err_o  out  NUM_PORTS  error strobe; present only with WB_OPENRAM_ERR_EN.
- ram_clk0  out  1  equals wb_clk_i.
- ram_csb0 / ram_web0  out  1  active-low chip select / write enable.
- ram_wmask0  out  4  byte write mask.
- ram_addr0  out  ADDR_WIDTH  word address.
- ram_din0  out  32  write data.
- ram_dout0  in  32  read data.

## Operation
- Window hit for port i: cyc&stb high and adr[31:ADDR_WIDTH+2] == BASE_i[31:ADDR_WIDTH+2]. RAM address is adr[ADDR_WIDTH+1:2].
- FSM states: IDLE, ISSUE, WAIT, ACK.
- IDLE: the round-robin search starts at last_grant+1 and grants the first hitting port. The grant index, we, sel, addr and data are registered.
- ISSUE (1 cycle): ram_csb0=0 and ram_web0=!we. ram_wmask0=sel on writes, 4'hF on reads. Writes go to ACK; reads go to WAIT.
- WAIT: counts READ_LATENCY cycles, then loads ram_dout0 into the granted port's wbs_dat_o and goes to ACK.
- ACK: wbs_ack_o[grant]=1 for exactly one cycle, last_grant updates, then IDLE.
- Abandoned request: if cyc drops while the port is in ISSUE or WAIT, the RAM operation completes and the ack is suppressed. wbs_dat_o is still updated.
- Ports that are not granted keep their wbs_dat_o. Their ack stays 0.
- Reset (asynchronous, any state): FSM goes to IDLE. ram_csb0=1, ram_web0=1, ram_wmask0=0, ram_addr0=0, ram_din0=0, all ack/err=0, all wbs_dat_o=0, last_grant=NUM_PORTS-1 (so port 0 has first priority).

## Timing
- Cycle 0: request seen in IDLE.
- Cycle 1: ISSUE.
- Write ack in cycle 2.
- Read ack and data in cycle 2+READ_LATENCY.
- Throughput: one access per 3 (write) or 3+READ_LATENCY (read) cycles. IDLE costs one cycle between back-to-back accesses.
- Simultaneous requests: exactly one grant per IDLE cycle. Round robin guarantees that each requesting port waits at most NUM_PORTS-1 other accesses.
- The master must drop stb at the edge where ack is seen. IDLE re-samples on the following cycle.

## Configuration
- WB_OPENRAM_ERR_EN defined: an out-of-window request (cyc&stb, address miss) raises wbs_err_o[i] for one cycle in the next cycle. It takes no RAM access and no arbitration slot.
- WB_OPENRAM_ERR_EN undefined: the wbs_err_o port is absent. Out-of-window requests are ignored (never acked), so another slave on that bus can respond.

## Structure
- Package wb_openram_pkg: FSM state enum (IDLE, ISSUE, WAIT, ACK), a latency-counter width localparam, and a window-match function.
- Sub-module wb_rr_arbiter: NUM_PORTS request vector plus last_grant in, one-hot grant and index out; purely combinational.

## Test plan
- Reset, then port 0 writes 32'hDEADBEEF to 0x3000_0010 with sel=4'hF: ram_csb0 low in cycle 1 with ram_addr0=4, ack in cycle 2. A following read returns 32'hDEADBEEF with ack in cycle 3 (READ_LATENCY=1).
- Byte write, sel=4'b0100, data 32'h00AA0000: ram_wmask0=4'b0100. A read-back shows only byte 2 changed.
- Ports 0 and 1 both request continuously: grants alternate 0,1,0,1, and neither ack stream stalls for more than one access.
- Port 1 read with cyc dropped in WAIT: no ack. wbs_dat_o[1] is updated and the FSM returns to IDLE.
- Out-of-window address 0x3000_1000 (ADDR_WIDTH=8): with WB_OPENRAM_ERR_EN, err pulses one cycle and ram_csb0 stays 1; without it, there is no ack, no err and no RAM access.
- wb_rst_i asserted mid-WAIT: all outputs go to their reset values immediately. The next request is served starting from port 0 priority.
